// File: rtl/console_uart.sv
// console_uart: 8N1 UART console that hands received bytes to a CPU and transmits bytes written by it.
// Ports:
//   CLK, RESET      rising-edge clock, synchronous active-high reset
//   CIN, CRDA, CACK received byte, byte-available flag, CPU consume pulse
//   COUT, CWR, CRDY byte to send, CPU write pulse, transmitter-ready flag
//   RXD, TXD        serial receive (asynchronous, idle high) and registered transmit lines
module console_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [7:0] CIN,
    output logic       CRDA,
    input  logic       CACK,
    input  logic [7:0] COUT,
    input  logic       CWR,
    output logic       CRDY,
    input  logic       RXD,
    output logic       TXD
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    logic [1:0]    sync_q;
    logic          rxd;
    state_e        rx_st_q, rx_st_d, tx_st_q, tx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]    rx_shf_q, rx_shf_d, tx_shf_q, tx_shf_d;
    logic          txd_q, txd_d;
    logic          rx_take, dv_q;
    logic [7:0]    cin_q;
    logic          crda_q;
    assign rxd = sync_q[1];
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q   <= 2'b11;
            rx_st_q  <= IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_shf_q <= '0;
            dv_q     <= 1'b0;
            cin_q    <= '0;
            crda_q   <= 1'b0;
            tx_st_q  <= IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_shf_q <= '0;
            txd_q    <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], RXD};
            rx_st_q  <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_shf_q <= rx_shf_d;
            dv_q     <= rx_take;
            // A delivery is accepted when the holding register is free or being consumed in the same cycle
            if (dv_q && (!crda_q || CACK)) begin
                cin_q  <= rx_shf_q;
                crda_q <= 1'b1;
            end else if (CACK) begin
                crda_q <= 1'b0;
            end
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_shf_q <= tx_shf_d;
            txd_q    <= txd_d;
        end
    end
    // Receiver: START waits half a bit so all later samples land mid-bit
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_shf_d = rx_shf_q;
        case (rx_st_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (!rxd) rx_st_d = START;
            end
            START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rxd ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_shf_d = {rxd, rx_shf_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = STOP;
            end
            STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_st_d  = IDLE;
            end
        endcase
    end
    // Transmitter: the shift register is consumed LSB first as each bit is put on the line
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + 1'b1;
        tx_bit_d = tx_bit_q;
        tx_shf_d = tx_shf_q;
        txd_d    = txd_q;
        case (tx_st_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (CWR) begin
                    tx_st_d  = START;
                    tx_shf_d = COUT;
                    txd_d    = 1'b0;
                end
            end
            START: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                tx_st_d  = DATA;
                txd_d    = tx_shf_q[0];
                tx_shf_d = tx_shf_q >> 1;
            end
            DATA: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                tx_st_d  = (tx_bit_q == 3'd7) ? STOP : DATA;
                txd_d    = (tx_bit_q == 3'd7) ? 1'b1 : tx_shf_q[0];
                tx_shf_d = tx_shf_q >> 1;
            end
            STOP: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                tx_st_d  = IDLE;
            end
        endcase
    end
    always_comb begin
        rx_take = (rx_st_q == STOP) && (rx_cnt_q == LAST) && rxd;
        CRDY    = (tx_st_q == IDLE);
        CIN     = cin_q;
        CRDA    = crda_q;
        TXD     = txd_q;
    end
endmodule

// File: tb/tb_console_uart.sv
// tb_console_uart: directed self-checking bench for console_uart with 8 clocks per bit.
module tb_console_uart;
    logic       CLK = 1'b0;
    logic       RESET, CACK, CWR, RXD;
    logic [7:0] COUT;
    logic [7:0] CIN;
    logic       CRDA, CRDY, TXD;
    int         checks = 0;
    int         errors = 0;
    console_uart #(.CLKS_PER_BIT(8)) dut (
        .CLK(CLK), .RESET(RESET), .CIN(CIN), .CRDA(CRDA), .CACK(CACK),
        .COUT(COUT), .CWR(CWR), .CRDY(CRDY), .RXD(RXD), .TXD(TXD)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    // Writes b and samples every bit mid-period; optionally pokes a busy write or acks RX alongside
    task automatic tx_frame(input logic [7:0] b, input logic [9:0] exp, input logic poke, input logic ack);
        logic [9:0] obs;
        COUT = b;
        CWR  = 1'b1;
        CACK = ack;
        tick(1);
        CWR  = 1'b0;
        CACK = 1'b0;
        COUT = 8'h00;
        check("tx_crdy_low", CRDY, 1'b0);
        if (ack) check("ack_with_cwr", CRDA, 1'b0);
        tick(4);
        for (int i = 0; i < 10; i++) begin
            obs[i] = TXD;
            if (poke && i == 2) begin
                COUT = 8'h55;
                CWR  = 1'b1;
                tick(1);
                CWR  = 1'b0;
                tick(7);
            end else if (i < 9) begin
                tick(8);
            end
        end
        check("tx_pattern", obs, exp);
        tick(3);
        check("tx_crdy_79", CRDY, 1'b0);
        tick(1);
        check("tx_crdy_80", CRDY, 1'b1);
        check("tx_idle_txd", TXD, 1'b1);
    endtask
    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic ack);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            if (ack && i == 9) begin
                tick(7);
                CACK = 1'b1;
                tick(1);
                CACK = 1'b0;
            end else begin
                tick(8);
            end
        end
        RXD = 1'b1;
    endtask
    task automatic ack_pulse();
        CACK = 1'b1;
        tick(1);
        CACK = 1'b0;
    endtask
    initial begin
        logic [9:0] f;
        RESET = 1'b1;
        CWR   = 1'b1;
        COUT  = 8'hFF;
        CACK  = 1'b1;
        RXD   = 1'b0;
        tick(3);
        check("rst_cin", CIN, 8'h00);
        check("rst_crda", CRDA, 1'b0);
        check("rst_crdy", CRDY, 1'b1);
        check("rst_txd", TXD, 1'b1);
        RESET = 1'b0;
        CWR   = 1'b0;
        CACK  = 1'b0;
        RXD   = 1'b1;
        tick(1);
        check("post_rst_crdy", CRDY, 1'b1);
        check("post_rst_txd", TXD, 1'b1);
        tick(10);
        tx_frame(8'h41, 10'h282, 1'b0, 1'b0);
        tx_frame(8'h41, 10'h282, 1'b1, 1'b0);
        tick(20);
        check("busy_no_tx", TXD, 1'b1);
        check("busy_crdy", CRDY, 1'b1);
        rx_frame(8'h5A, 1'b1, 1'b0);
        tick(2);
        check("rx_5a_cin", CIN, 8'h5A);
        check("rx_5a_crda", CRDA, 1'b1);
        ack_pulse();
        check("ack_crda", CRDA, 1'b0);
        check("ack_cin_hold", CIN, 8'h5A);
        ack_pulse();
        check("idle_ack_crda", CRDA, 1'b0);
        check("idle_ack_cin", CIN, 8'h5A);
        rx_frame(8'h11, 1'b1, 1'b0);
        tick(2);
        check("rx_11_cin", CIN, 8'h11);
        rx_frame(8'h22, 1'b1, 1'b0);
        tick(2);
        check("overrun_cin", CIN, 8'h11);
        check("overrun_crda", CRDA, 1'b1);
        rx_frame(8'h22, 1'b1, 1'b1);
        check("ack_deliver_cin", CIN, 8'h22);
        check("ack_deliver_crda", CRDA, 1'b1);
        ack_pulse();
        rx_frame(8'h33, 1'b0, 1'b0);
        tick(20);
        check("frame_err_crda", CRDA, 1'b0);
        check("frame_err_cin", CIN, 8'h22);
        RXD = 1'b0;
        tick(2);
        RXD = 1'b1;
        tick(20);
        check("glitch_crda", CRDA, 1'b0);
        rx_frame(8'hA5, 1'b1, 1'b0);
        tick(2);
        check("post_glitch_cin", CIN, 8'hA5);
        check("post_glitch_crda", CRDA, 1'b1);
        tx_frame(8'hC3, 10'h386, 1'b0, 1'b1);
        rx_frame(8'h3C, 1'b1, 1'b0);
        tick(2);
        check("pre_rst_crda", CRDA, 1'b1);
        f = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 44; c++) begin
            RXD  = f[c / 8];
            CWR  = (c == 8);
            COUT = 8'hA5;
            tick(1);
        end
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        RXD   = 1'b1;
        check("mid_rst_txd", TXD, 1'b1);
        check("mid_rst_crdy", CRDY, 1'b1);
        check("mid_rst_crda", CRDA, 1'b0);
        check("mid_rst_cin", CIN, 8'h00);
        tick(100);
        check("mid_rst_no_deliver", CRDA, 1'b0);
        check("mid_rst_txd_idle", TXD, 1'b1);
        fork
            tx_frame(8'h7E, 10'h2FC, 1'b0, 1'b0);
            rx_frame(8'h7E, 1'b1, 1'b0);
        join
        check("final_cin", CIN, 8'h7E);
        check("final_crda", CRDA, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
